// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one system RAM port between instruction fetch and
// the bus data port. Data has default priority. A starvation counter forces an
// instruction grant after MaxInstrWait consecutive denied instruction cycles.
// Each response is returned to the side that issued the access, one cycle later.
module ram_port_arbiter #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MaxInstrWait = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   instr_req_i,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam logic [3:0] StarveMax = 4'(MaxInstrWait);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       we_q;
  logic       starve_hit;

  // Grant decision: data wins unless instruction fetch has waited too long.
  always_comb begin
    starve_hit  = instr_req_i && (starve_cnt == StarveMax);
    data_gnt_o  = data_req_i && !starve_hit;
    instr_gnt_o = instr_req_i && !data_gnt_o;
  end

  // RAM port mux: winner's fields, all zero when nothing is granted.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (data_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (instr_gnt_o) begin
      mem_req_o  = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = instr_addr_i;
    end
  end

  // Response state, registered write flag and starvation counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      we_q       <= 1'b0;
    end else begin
      if (instr_gnt_o) begin
        state <= RESP_I;
      end else if (data_gnt_o) begin
        state <= RESP_D;
      end else begin
        state <= IDLE;
      end

      if (data_gnt_o) begin
        we_q <= data_we_i;
      end

      if (!instr_req_i || instr_gnt_o) begin
        starve_cnt <= '0;
      end else if (starve_cnt != StarveMax) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Route RAM read data to the side whose access was granted last cycle.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    case (state)
      RESP_I: begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mem_rdata_i;
      end
      RESP_D: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = we_q ? '0 : mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule
